reg_dump_tx: RTL

REG_DUMP_TX -- requirements
Module: reg_dump_tx

---
 rtl/reg_dump_tx_pkg.sv | 23 ++
 rtl/reg_dump_tx_uart_tx_byte.sv | 63 ++++++
 rtl/reg_dump_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the register-dump UART transmitter.
// REG_DUMP_CHECKSUM_EN adds the CSUM state to the FSM enum.
package reg_dump_tx_pkg;

    localparam logic [7:0] DUMP_HDR       = 8'hA5;
    localparam int         NUM_REGS       = 32;
    localparam int         BYTES_PER_WORD = 4;

    localparam logic [4:0] LAST_REG  = 5'(NUM_REGS - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PC,
        REGS
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        CSUM
`endif
    } dump_state_e;

endpackage

// File: rtl/reg_dump_tx_uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, idle high. ready rises in the last stop-bit
// cycle so a byte accepted then starts its start bit with no idle gap.
module uart_tx_byte #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       last,
    output logic       busy,
    output logic       tx
);

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    logic        active_q;
    logic [15:0] div_cnt_q;
    logic [3:0]  bit_idx_q;
    logic [7:0]  shreg_q;
    logic        tx_q;

    // bit_idx: 0 = start, 1..8 = data, 9 = stop
    assign last  = active_q && (bit_idx_q == 4'd9) && (div_cnt_q == DIV_MAX);
    assign ready = !active_q || last;
    assign busy  = active_q;
    assign tx    = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
            div_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else if (valid && ready) begin
            active_q  <= 1'b1;
            tx_q      <= 1'b0;
            div_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= data;
        end else if (active_q) begin
            if (div_cnt_q == DIV_MAX) begin
                div_cnt_q <= '0;
                if (bit_idx_q == 4'd9) begin
                    active_q <= 1'b0;
                end else begin
                    bit_idx_q <= bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd8) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[7:1]};
                    end
                end
            end else begin
                div_cnt_q <= div_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Dumps header, PC and R0..R31 as a UART frame on trigger.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [31:0] pc_i,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    dump_state_e state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [4:0]  reg_idx_q, reg_idx_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] word_q, word_d;
    logic        done_q;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic       tx_valid, tx_ready, tx_last, tx_busy;
    logic [7:0] tx_byte;

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_uart (
        .clk   (clk),
        .rst   (rst),
        .valid (tx_valid),
        .data  (tx_byte),
        .ready (tx_ready),
        .last  (tx_last),
        .busy  (tx_busy),
        .tx    (tx)
    );

    // The state names the byte currently on the wire; the byte offered to the
    // serialiser is the one that follows it.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        reg_idx_d  = reg_idx_q;
        pc_d       = pc_q;
        word_d     = word_q;
        tx_valid   = 1'b1;
        tx_byte    = DUMP_HDR;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                tx_valid = trigger;
                if (trigger && tx_ready) begin
                    state_d    = HDR;
                    pc_d       = pc_i;
                    byte_cnt_d = '0;
                    reg_idx_d  = '0;
                end
            end
            HDR: begin
                tx_byte = pc_q[7:0];
                if (tx_ready) begin
                    state_d    = PC;
                    byte_cnt_d = 2'd1;
                end
            end
            PC: begin
                tx_byte = pc_q[{byte_cnt_q, 3'b000} +: 8];
                if (tx_ready) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) state_d = REGS;
                end
            end
            REGS: begin
                // Byte 0 comes straight from the regfile and the word is held for bytes 1..3
                tx_byte = (byte_cnt_q == 2'd0) ? rf_rdata[7:0] : word_q[{byte_cnt_q, 3'b000} +: 8];
                if (tx_ready) begin
                    if (byte_cnt_q == 2'd0) word_d = rf_rdata;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (reg_idx_q == LAST_REG) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = IDLE;
`endif
                        end else begin
                            reg_idx_d = reg_idx_q + 5'd1;
                        end
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                tx_byte = csum_q;
                if (tx_ready) state_d = IDLE;
            end
`endif
            default: begin
                tx_valid = 1'b0;
                state_d  = IDLE;
            end
        endcase
`ifdef REG_DUMP_CHECKSUM_EN
        if (state_q == IDLE) begin
            if (tx_valid && tx_ready) csum_d = '0;
        end else if (state_q != CSUM && tx_ready) begin
            csum_d = csum_q ^ tx_byte;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            reg_idx_q  <= '0;
            pc_q       <= '0;
            word_q     <= '0;
            done_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            reg_idx_q  <= reg_idx_d;
            pc_q       <= pc_d;
            word_q     <= word_d;
            // In IDLE any byte still on the wire is the last byte of a frame
            done_q     <= (state_q == IDLE) && tx_last;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rf_raddr = (state_q == REGS) ? reg_idx_q : 5'd0;
    assign busy     = (state_q != IDLE) || tx_busy;
    assign done     = done_q;

endmodule
